// File: rtl/countdown_timer.sv
// Bomb countdown timer: counts seconds down from START_SECONDS, applies strike
// penalties, freezes on defuse and pulses time_expired once when time runs out.
module countdown_timer #(
    parameter int unsigned CLK_HZ          = 27000000,
    parameter int unsigned START_SECONDS   = 300,
    parameter int unsigned PENALTY_SECONDS = 15,
    parameter int unsigned WARN_SECONDS    = 30
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       begin_timer,
    input  logic       stop_timer,
    input  logic       strike,
    output logic       time_expired,
    output logic       running,
    output logic       warning,
    output logic       sec_tick,
    output logic [9:0] seconds_left,
    output logic [3:0] min_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] sec_ones,
    output logic [1:0] state
);

    localparam int unsigned SW = 10;
    localparam int unsigned PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_HZ - 1);

    localparam logic [1:0] S_IDLE     = 2'b00;
    localparam logic [1:0] S_COUNTING = 2'b01;
    localparam logic [1:0] S_FROZEN   = 2'b10;
    localparam logic [1:0] S_EXPIRED  = 2'b11;

    logic [1:0]    state_q, state_d;
    logic [SW-1:0] secs_q, secs_d;
    logic [PW-1:0] presc_q, presc_d;
    logic          expired_q, expired_d;
    logic          running_q, running_d;
    logic          warning_q, warning_d;
    logic          tick_q, tick_d;
    logic [3:0]    min_q, tens_q, ones_q;

    logic          tick_c;
    logic [SW-1:0] dec_c;
    logic [SW-1:0] rem_c;
    logic [3:0]    min_c, tens_c, ones_c;

    // Next-state: restart wins, then defuse, then combined tick/strike decrement
    always_comb begin
        state_d   = state_q;
        secs_d    = secs_q;
        presc_d   = presc_q;
        expired_d = 1'b0;
        tick_d    = 1'b0;
        dec_c     = '0;
        tick_c    = (state_q == S_COUNTING) && (presc_q == PRESC_MAX);

        if (begin_timer) begin
            state_d = S_COUNTING;
            secs_d  = SW'(START_SECONDS);
            presc_d = '0;
        end else if (state_q == S_COUNTING) begin
            if (stop_timer) begin
                // Defuse wins ties: the pending tick and strike are dropped
                state_d = S_FROZEN;
            end else begin
                presc_d = tick_c ? '0 : presc_q + PW'(1);
                tick_d  = tick_c;
                dec_c   = (tick_c ? SW'(1) : SW'(0))
                        + (strike ? SW'(PENALTY_SECONDS) : SW'(0));
                if (dec_c != '0) begin
                    if (secs_q <= dec_c) begin
                        secs_d    = '0;
                        expired_d = 1'b1;
                        state_d   = S_EXPIRED;
                    end else begin
                        secs_d = secs_q - dec_c;
                    end
                end
            end
        end

        running_d = (state_d == S_COUNTING);
        warning_d = running_d && (secs_d != '0) && (secs_d <= SW'(WARN_SECONDS));
    end

    // Binary to M:SS digits by repeated compare/subtract (max 599 -> 9:59)
    always_comb begin
        rem_c  = secs_q;
        min_c  = '0;
        tens_c = '0;
        for (int i = 0; i < 9; i++) begin
            if (rem_c >= SW'(60)) begin
                rem_c = rem_c - SW'(60);
                min_c = min_c + 4'd1;
            end
        end
        for (int i = 0; i < 5; i++) begin
            if (rem_c >= SW'(10)) begin
                rem_c  = rem_c - SW'(10);
                tens_c = tens_c + 4'd1;
            end
        end
        ones_c = rem_c[3:0];
    end

    // State, counters and registered status outputs
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= S_IDLE;
            secs_q    <= '0;
            presc_q   <= '0;
            expired_q <= 1'b0;
            running_q <= 1'b0;
            warning_q <= 1'b0;
            tick_q    <= 1'b0;
            min_q     <= '0;
            tens_q    <= '0;
            ones_q    <= '0;
        end else begin
            state_q   <= state_d;
            secs_q    <= secs_d;
            presc_q   <= presc_d;
            expired_q <= expired_d;
            running_q <= running_d;
            warning_q <= warning_d;
            tick_q    <= tick_d;
            min_q     <= min_c;
            tens_q    <= tens_c;
            ones_q    <= ones_c;
        end
    end

    assign state        = state_q;
    assign seconds_left = secs_q;
    assign time_expired = expired_q;
    assign running      = running_q;
    assign warning      = warning_q;
    assign sec_tick     = tick_q;
    assign min_ones     = min_q;
    assign sec_tens     = tens_q;
    assign sec_ones     = ones_q;

endmodule

// File: tb/tb_countdown_timer.sv
// Directed bench for countdown_timer: three instances (START 5, 125, 40) share
// one stimulus stream; each check targets the instance whose start value fits.
module tb_countdown_timer;

    logic clock = 1'b0;
    logic reset = 1'b0;
    logic begin_timer = 1'b0;
    logic stop_timer = 1'b0;
    logic strike = 1'b0;

    logic       expd [3];
    logic       run  [3];
    logic       warn [3];
    logic       tk   [3];
    logic [9:0] secs [3];
    logic [3:0] mo   [3];
    logic [3:0] st10 [3];
    logic [3:0] so   [3];
    logic [1:0] st   [3];

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    countdown_timer #(.CLK_HZ(4), .START_SECONDS(5), .PENALTY_SECONDS(15), .WARN_SECONDS(30)) u_a (
        .clock(clock), .reset(reset), .begin_timer(begin_timer), .stop_timer(stop_timer),
        .strike(strike), .time_expired(expd[0]), .running(run[0]), .warning(warn[0]),
        .sec_tick(tk[0]), .seconds_left(secs[0]), .min_ones(mo[0]), .sec_tens(st10[0]),
        .sec_ones(so[0]), .state(st[0]));

    countdown_timer #(.CLK_HZ(4), .START_SECONDS(125), .PENALTY_SECONDS(15), .WARN_SECONDS(30)) u_b (
        .clock(clock), .reset(reset), .begin_timer(begin_timer), .stop_timer(stop_timer),
        .strike(strike), .time_expired(expd[1]), .running(run[1]), .warning(warn[1]),
        .sec_tick(tk[1]), .seconds_left(secs[1]), .min_ones(mo[1]), .sec_tens(st10[1]),
        .sec_ones(so[1]), .state(st[1]));

    countdown_timer #(.CLK_HZ(4), .START_SECONDS(40), .PENALTY_SECONDS(15), .WARN_SECONDS(30)) u_c (
        .clock(clock), .reset(reset), .begin_timer(begin_timer), .stop_timer(stop_timer),
        .strike(strike), .time_expired(expd[2]), .running(run[2]), .warning(warn[2]),
        .sec_tick(tk[2]), .seconds_left(secs[2]), .min_ones(mo[2]), .sec_tens(st10[2]),
        .sec_ones(so[2]), .state(st[2]));

    // n cycles; inputs r/b/s/k apply on the first cycle only; expected values after the n-th edge
    typedef struct {
        int n;
        bit r, b, s, k;
        int st, secs;
        bit ex, run, warn, tk;
    } vec_t;

    vec_t tv[$];

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic step(input bit r, input bit b, input bit s, input bit k);
        reset = r; begin_timer = b; stop_timer = s; strike = k;
        @(posedge clock);
        #1;
        reset = 1'b0; begin_timer = 1'b0; stop_timer = 1'b0; strike = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0);
    endtask

    initial begin
        //            n  r  b  s  k  st secs ex run warn tk
        tv.push_back('{1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0});   // reset
        tv.push_back('{1, 0, 1, 0, 0, 1, 5, 0, 1, 1, 0});   // arm
        tv.push_back('{3, 0, 0, 0, 0, 1, 5, 0, 1, 1, 0});
        tv.push_back('{1, 0, 0, 0, 0, 1, 4, 0, 1, 1, 1});   // 4th cycle after arm
        tv.push_back('{1, 0, 0, 0, 0, 1, 4, 0, 1, 1, 0});
        tv.push_back('{3, 0, 0, 0, 0, 1, 3, 0, 1, 1, 1});
        tv.push_back('{4, 0, 0, 0, 0, 1, 2, 0, 1, 1, 1});
        tv.push_back('{4, 0, 0, 0, 0, 1, 1, 0, 1, 1, 1});
        tv.push_back('{4, 0, 0, 0, 0, 3, 0, 1, 0, 0, 1});   // expire
        tv.push_back('{1, 0, 0, 0, 0, 3, 0, 0, 0, 0, 0});   // pulse is one cycle
        tv.push_back('{1, 0, 0, 0, 1, 3, 0, 0, 0, 0, 0});   // strike ignored in EXPIRED
        tv.push_back('{1, 0, 1, 0, 0, 1, 5, 0, 1, 1, 0});   // restart from EXPIRED
        tv.push_back('{4, 0, 0, 0, 0, 1, 4, 0, 1, 1, 1});
        tv.push_back('{4, 0, 0, 0, 0, 1, 3, 0, 1, 1, 1});
        tv.push_back('{1, 0, 1, 0, 0, 1, 5, 0, 1, 1, 0});   // restart mid-count
        tv.push_back('{3, 0, 0, 0, 0, 1, 5, 0, 1, 1, 0});   // prescaler restarted
        tv.push_back('{1, 0, 0, 0, 0, 1, 4, 0, 1, 1, 1});
        tv.push_back('{1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0});   // reset beats begin
        tv.push_back('{1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0});   // strike in IDLE
        tv.push_back('{1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0});   // stop in IDLE
        tv.push_back('{1, 0, 1, 0, 0, 1, 5, 0, 1, 1, 0});
        tv.push_back('{3, 0, 0, 0, 0, 1, 5, 0, 1, 1, 0});
        tv.push_back('{1, 0, 0, 1, 0, 2, 5, 0, 0, 0, 0});   // stop beats coincident tick
        tv.push_back('{5, 0, 0, 0, 1, 2, 5, 0, 0, 0, 0});   // FROZEN holds
        tv.push_back('{1, 0, 1, 0, 0, 1, 5, 0, 1, 1, 0});   // restart from FROZEN
        tv.push_back('{1, 0, 0, 0, 1, 3, 0, 1, 0, 0, 0});   // strike 15 >= 5 saturates
        tv.push_back('{1, 0, 0, 0, 0, 3, 0, 0, 0, 0, 0});

        for (int i = 0; i < tv.size(); i++) begin
            step(tv[i].r, tv[i].b, tv[i].s, tv[i].k);
            idle(tv[i].n - 1);
            chk($sformatf("row%0d.state", i), int'(st[0]),   tv[i].st);
            chk($sformatf("row%0d.secs", i),  int'(secs[0]), tv[i].secs);
            chk($sformatf("row%0d.expired", i), int'(expd[0]), int'(tv[i].ex));
            chk($sformatf("row%0d.running", i), int'(run[0]),  int'(tv[i].run));
            chk($sformatf("row%0d.warning", i), int'(warn[0]), int'(tv[i].warn));
            chk($sformatf("row%0d.sec_tick", i), int'(tk[0]),  int'(tv[i].tk));
        end

        // Defuse on the very last tick: freeze at 1, no expiry
        step(1, 0, 0, 0);
        chk("rst.digits", int'(mo[0]) + int'(st10[0]) + int'(so[0]), 0);
        step(0, 1, 0, 0);
        idle(16);
        chk("final.secs", int'(secs[0]), 1);
        idle(3);
        step(0, 0, 1, 0);
        chk("final.state", int'(st[0]), 2);
        chk("final.secs_hold", int'(secs[0]), 1);
        chk("final.no_expire", int'(expd[0]), 0);
        chk("final.no_tick", int'(tk[0]), 0);
        chk("final.warn_off", int'(warn[0]), 0);
        step(0, 0, 0, 1);
        step(0, 0, 0, 1);
        chk("final.strike_secs", int'(secs[0]), 1);
        chk("final.strike_state", int'(st[0]), 2);
        chk("final.strike_noexp", int'(expd[0]), 0);

        // BCD digits from the START=125 instance
        step(1, 0, 0, 0);
        step(0, 1, 0, 0);
        chk("bcd.load", int'(secs[1]), 125);
        idle(1);
        chk("bcd.min125", int'(mo[1]), 2);
        chk("bcd.tens125", int'(st10[1]), 0);
        chk("bcd.ones125", int'(so[1]), 5);
        chk("bcd.warn125", int'(warn[1]), 0);
        idle(23);
        chk("bcd.secs119", int'(secs[1]), 119);
        idle(1);
        chk("bcd.min119", int'(mo[1]), 1);
        chk("bcd.tens119", int'(st10[1]), 5);
        chk("bcd.ones119", int'(so[1]), 9);

        // Strike penalties on the START=40 instance
        step(1, 0, 0, 0);
        step(0, 1, 0, 0);
        chk("pen.load", int'(secs[2]), 40);
        chk("pen.warn40", int'(warn[2]), 0);
        step(0, 0, 0, 1);
        chk("pen.secs25", int'(secs[2]), 25);
        chk("pen.warn25", int'(warn[2]), 1);
        idle(2);
        chk("pen.hold25", int'(secs[2]), 25);
        step(0, 0, 0, 1);
        chk("pen.secs9", int'(secs[2]), 9);
        chk("pen.tick9", int'(tk[2]), 1);
        step(0, 0, 0, 1);
        chk("pen.secs0", int'(secs[2]), 0);
        chk("pen.expired", int'(expd[2]), 1);
        chk("pen.state", int'(st[2]), 3);
        idle(1);
        chk("pen.expired_once", int'(expd[2]), 0);
        step(0, 0, 0, 1);
        chk("pen.post_strike", int'(secs[2]), 0);
        chk("pen.post_noexp", int'(expd[2]), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
